div_operand_sequencer: RTL and testbench

- Front-panel sequencer between the button debouncer and the divider core on the Spartan-3E board.
- Consumes the debouncer's one-cycle press pulse and the slide switches. Captures the dividend, then the divisor.
- Issues a start handshake to the divider, latches quotient/remainder on completion and drives the LEDs.
- Rejects divide-by-zero and recovers from a divider that never completes (watchdog).

---
 rtl/div_operand_sequencer_pkg.sv | 18 +
 rtl/div_watchdog.sv | 34 +++
 rtl/div_operand_sequencer.sv | 107 ++++++++++
 tb/tb_div_operand_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/div_operand_sequencer_pkg.sv
// div_operand_sequencer_pkg: shared state encodings and constants for the front-panel divide sequencer
package div_operand_sequencer_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [2:0] {
        S_GET_A = 3'd0,
        S_GET_B = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_SHOW  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    // Wide enough for any sensible LED bank; the top slices off what it needs.
    localparam logic [63:0] LED_ERR_ALL = '1;

endpackage

// File: rtl/div_watchdog.sv
// div_watchdog: cycle counter that flags when a pending division has run out of time
module div_watchdog #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Clear dominates; otherwise count only while enabled.
    always_comb begin
        cnt_d = clr ? '0 : (en ? cnt_q + 1'b1 : cnt_q);
    end

    // Expiry fires in the cycle the count reaches its last value, so the caller
    // leaves its wait state exactly TIMEOUT cycles after the clear.
    always_comb begin
        expired = en && !clr && (cnt_d == LAST);
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/div_operand_sequencer.sv
// div_operand_sequencer: captures two operands from switches, runs the divider and shows the result on LEDs
module div_operand_sequencer
    import div_operand_sequencer_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_pulse,
    input  logic [WIDTH-1:0]   sw,
    input  logic               div_done,
    input  logic [WIDTH-1:0]   quotient_in,
    input  logic [WIDTH-1:0]   remainder_in,
    output logic [WIDTH-1:0]   dividend,
    output logic [WIDTH-1:0]   divisor,
    output logic               div_start,
    output logic [2*WIDTH-1:0] led,
    output logic               error,
    output logic [2:0]         state_dbg
);

    state_t state_q, state_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic wd_clr, wd_en, wd_expired;

    // The watchdog restarts on every issued division and only advances while
    // waiting without a completion, so a same-cycle done always wins.
    always_comb begin
        wd_clr = (state_q == S_START);
        wd_en  = (state_q == S_WAIT) && !div_done;
    end

    div_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_GET_A;
        else     state_q <= state_d;
    end

    // Next-state logic; presses in START/WAIT and done outside WAIT are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_GET_A: state_d = btn_pulse ? S_GET_B : S_GET_A;
            S_GET_B: state_d = !btn_pulse ? S_GET_B : ((sw == '0) ? S_ERR : S_START);
            S_START: state_d = S_WAIT;
            S_WAIT:  state_d = div_done ? S_SHOW : (wd_expired ? S_ERR : S_WAIT);
            S_SHOW:  state_d = btn_pulse ? S_GET_A : S_SHOW;
            S_ERR:   state_d = btn_pulse ? S_GET_A : S_ERR;
            default: state_d = S_GET_A;
        endcase
    end

    // Operand and result capture; values hold until their next capture point.
    always_comb begin
        dividend_d = (state_q == S_GET_A && btn_pulse) ? sw : dividend_q;
        divisor_d  = (state_q == S_GET_B && btn_pulse) ? sw : divisor_q;
        quot_d     = (state_q == S_WAIT && div_done) ? quotient_in : quot_q;
        rem_d      = (state_q == S_WAIT && div_done) ? remainder_in : rem_q;
    end

    // Operand and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
        end else begin
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
        end
    end

    // Moore outputs; the LED bank previews the switches while operands are entered.
    always_comb begin
        div_start = (state_q == S_START);
        error     = (state_q == S_ERR);
        state_dbg = state_q;
        dividend  = dividend_q;
        divisor   = divisor_q;
        case (state_q)
            S_GET_A:         led = {{WIDTH{1'b0}}, sw};
            S_GET_B:         led = {dividend_q, sw};
            S_START, S_WAIT: led = {dividend_q, divisor_q};
            S_SHOW:          led = {quot_q, rem_q};
            S_ERR:           led = LED_ERR_ALL[2*WIDTH-1:0];
            default:         led = '0;
        endcase
    end

endmodule

// File: tb/tb_div_operand_sequencer.sv
// tb_div_operand_sequencer: directed and randomized operations checked against an arithmetic divider model
module tb_div_operand_sequencer;

    localparam int W  = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         btn_pulse;
    logic [W-1:0] sw;
    logic         div_done;
    logic [W-1:0] quotient_in;
    logic [W-1:0] remainder_in;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         div_start;
    logic [2*W-1:0] led;
    logic         error;
    logic [2:0]   state_dbg;

    int total = 0;
    int bad = 0;
    int nstart = 0;
    int consec = 0;
    logic prev_start = 1'b0;

    div_operand_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_pulse    (btn_pulse),
        .sw           (sw),
        .div_done     (div_done),
        .quotient_in  (quotient_in),
        .remainder_in (remainder_in),
        .dividend     (dividend),
        .divisor      (divisor),
        .div_start    (div_start),
        .led          (led),
        .error        (error),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (div_start && prev_start) consec++;
        if (div_start) nstart++;
        prev_start = div_start;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic b, input logic d, input logic [W-1:0] s);
        btn_pulse = b;
        div_done  = d;
        sw        = s;
        @(posedge clk);
        #1;
        btn_pulse = 1'b0;
        div_done  = 1'b0;
    endtask

    // One full operation as a user would perform it. The bench plays the divider:
    // it answers lat cycles into WAIT with the true quotient and remainder.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                         input bit noisy, input bit press_on_done);
        int n0;
        int fin;
        logic [W-1:0] q, r;
        n0 = nstart;
        cyc(1'b1, 1'b0, a);
        check("cap_a_state", state_dbg, 1);
        check("dividend", dividend, a);
        sw = b;
        #1;
        check("led_get_b", led, {a, b});
        cyc(1'b1, 1'b0, b);
        if (b == 0) begin
            check("dz_state", state_dbg, 5);
            check("dz_error", error, 1);
            check("dz_led", led, 8'hFF);
            cyc(1'b0, 1'b0, b);
            check("dz_no_start", nstart - n0, 0);
            fin = 5;
        end else begin
            q = a / b;
            r = a % b;
            check("start_state", state_dbg, 2);
            check("start_pulse", div_start, 1);
            check("divisor", divisor, b);
            check("led_run", led, {a, b});
            quotient_in  = 4'($urandom);
            remainder_in = 4'($urandom);
            cyc(noisy ? 1'($urandom_range(0, 1)) : 1'b0, noisy ? 1'($urandom_range(0, 1)) : 1'b0, b);
            check("wait_state", state_dbg, 3);
            check("start_single", div_start, 0);
            fin = 5;
            for (int k = 1; k < TO; k++) begin
                if (k == lat) begin
                    quotient_in  = q;
                    remainder_in = r;
                    cyc(press_on_done || (noisy && 1'($urandom_range(0, 1))), 1'b1, b);
                    fin = 4;
                    break;
                end
                quotient_in  = 4'($urandom);
                remainder_in = 4'($urandom);
                cyc(noisy ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, b);
                if (k < TO - 1) check("wait_hold", state_dbg, 3);
            end
            check("end_state", state_dbg, fin);
            check("end_led", led, (fin == 4) ? {q, r} : 8'hFF);
            check("end_error", error, (fin == 5) ? 1 : 0);
            check("one_start", nstart - n0, 1);
        end
        quotient_in  = 4'($urandom);
        remainder_in = 4'($urandom);
        cyc(1'b0, noisy ? 1'($urandom_range(0, 1)) : 1'b0, 4'($urandom));
        check("late_done_ignored", state_dbg, fin);
        check("operands_held", {dividend, divisor}, {a, b});
        sw = 4'($urandom);
        cyc(1'b1, 1'b0, sw);
        check("back_to_a", state_dbg, 0);
        check("led_preview", led, {4'h0, sw});
    endtask

    initial begin
        int n0;
        rst = 1'b1;
        btn_pulse = 1'b0;
        div_done = 1'b0;
        sw = '0;
        quotient_in = '0;
        remainder_in = '0;
        #12;
        check("rst_state", state_dbg, 0);
        check("rst_led", led, 0);
        check("rst_start", div_start, 0);
        check("rst_error", error, 0);
        check("rst_operands", {dividend, divisor}, 0);
        rst = 1'b0;

        // reset while a division is in flight
        cyc(1'b1, 1'b0, 4'd6);
        cyc(1'b1, 1'b0, 4'd3);
        cyc(1'b0, 1'b0, 4'd3);
        cyc(1'b0, 1'b0, 4'd0);
        check("mid_wait", state_dbg, 3);
        rst = 1'b1;
        #1;
        check("async_rst_state", state_dbg, 0);
        check("async_rst_led", led, 0);
        check("async_rst_start", div_start, 0);
        #2;
        rst = 1'b0;
        n0 = nstart;
        quotient_in = 4'd2;
        remainder_in = 4'd0;
        cyc(1'b0, 1'b1, 4'd0);
        check("post_rst_done_ignored", state_dbg, 0);
        check("post_rst_no_start", nstart - n0, 0);
        check("post_rst_dividend", dividend, 0);

        // done in GET_A is ignored
        cyc(1'b0, 1'b1, 4'd2);
        check("done_in_get_a", state_dbg, 0);

        do_op(4'd13, 4'd4, 10, 1'b0, 1'b0);
        do_op(4'd9, 4'd0, 1, 1'b0, 1'b0);
        do_op(4'd5, 4'd2, 99, 1'b0, 1'b0);
        do_op(4'd11, 4'd3, 15, 1'b0, 1'b0);
        do_op(4'd8, 4'd5, 4, 1'b1, 1'b1);

        n0 = nstart;
        do_op(4'd15, 4'd2, 3, 1'b0, 1'b0);
        do_op(4'd7, 4'd7, 1, 1'b0, 1'b0);
        check("two_starts", nstart - n0, 2);

        for (int i = 0; i < 25; i++) begin
            do_op(4'($urandom), 4'($urandom), int'($urandom_range(1, 20)), 1'b1,
                  1'($urandom_range(0, 1)));
        end

        check("no_back_to_back_start", consec, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
